uart_rx_console: RTL and testbench
==================================

// Module: uart_rx_console
// PURPOSE
//  Receive-side console bridge. Deserialises 8N1 UART from the board's USB-UART pin
//  and buffers bytes in a small FIFO. Presents bytes to Wrapper's CONSOLE_IN port
//  using the CONSOLE_IN_valid / CONSOLE_IN_ack four-phase handshake.
//  Sits directly upstream of Wrapper, in the top level, beside the TX bridge.
// PARAMETERS
//  CLK_FREQ    100_000_000  CLK frequency in Hz
//  BAUD        115200       line rate; DIV = CLK_FREQ/BAUD (truncated), DIV >= 8 required
//  FIFO_DEPTH  4            byte FIFO entries; power of two, >= 2
// PORTS
//  CLK               in   1   system clock; all state on rising edge
//  RESET             in   1   asynchronous, active-high reset
//  RX                in   1   serial input, idle high, asynchronous to CLK
//  CONSOLE_IN        out  8   byte offered to Wrapper; stable while CONSOLE_IN_valid=1
//  CONSOLE_IN_valid  out  1   byte available
//  CONSOLE_IN_ack    in   1   Wrapper acknowledge (level)
//  FIFO_COUNT        out  clog2(FIFO_DEPTH)+1  bytes held in FIFO (excludes byte on CONSOLE_IN)
//  RX_OVERRUN        out  1   sticky; set when a good byte is dropped because FIFO full
//  FRAME_ERR         out  1   one-cycle pulse on bad stop bit
// BEHAVIOUR
//  Reset (async, any time): outputs 0, CONSOLE_IN=8'h00, both FSMs idle, FIFO empty.
//   RX synchroniser flops = 1; RX_OVERRUN cleared (only reset clears it).
//   A partial frame in flight at reset is discarded.
//  RX path: 2-flop synchroniser -> rx_s; rx_q = rx_s delayed 1 cycle.
//   Baud counter is clog2(DIV) bits wide.
//  RX FSM:
//   IDLE : on rx_q=1 & rx_s=0 (falling edge), clear counter -> START.
//   START: at counter = DIV/2-1 sample rx_s.
//          0 -> DATA (counter=0, bit=0); 1 -> glitch, back to IDLE.
//   DATA : every DIV cycles sample rx_s into shift[bit], LSB first.
//          After bit 7 -> STOP.
//   STOP : after DIV cycles sample rx_s.
//          1 -> push byte. 0 -> FRAME_ERR=1 for that cycle, byte discarded.
//          Either way -> IDLE; a new start needs a fresh 1->0 edge (break is not re-triggered).
//  FIFO: synchronous, pointers wrap modulo FIFO_DEPTH.
//   Push when full and no pop in the same cycle: byte dropped, RX_OVERRUN<=1.
//   Push and pop in the same cycle when full: both happen, count unchanged, no overrun.
//   Push and pop in the same cycle when empty: no bypass; pop waits until next cycle.
//  Output FSM (four-phase handshake):
//   O_IDLE : if FIFO non-empty, pop; CONSOLE_IN<=head, valid<=1 -> O_VALID.
//   O_VALID: hold byte and valid; on ack=1 -> O_WAIT.
//   O_WAIT : valid stays 1; on ack=0 -> valid<=0 -> O_IDLE.
//   Valid is low for at least 1 cycle between bytes.
//   ack=1 seen in O_IDLE is ignored.
//  Latency: stop-sample cycle T pushes; FIFO non-empty at T+1; valid=1 at T+2
//   (FIFO empty and output FSM idle beforehand).
//  RX FSM and output FSM are independent; reception continues during a handshake.
// TESTING (CLK_FREQ=1_000_000, BAUD=100_000 -> DIV=10)
//  1. Send 8'h41 -> valid=1 at stop-sample+2 with CONSOLE_IN=8'h41.
//     Raise ack, then drop it -> valid=0 the cycle after ack falls; FIFO_COUNT=0.
//  2. Send 8'h50, 8'h41, 8'h0D back-to-back with ack withheld -> FIFO_COUNT=2, CONSOLE_IN=8'h50.
//     Then 3 handshakes -> bytes delivered in order 50,41,0D.
//  3. Withhold ack, send 6 bytes 01..06 -> 01 on CONSOLE_IN, 02..05 in FIFO, 06 dropped.
//     RX_OVERRUN=1 and stays 1 after the FIFO drains.
//  4. Frame 8'hA5 with stop bit 0 -> one FRAME_ERR pulse, valid stays 0.
//     A following 8'h33 is received correctly.
//  5. Low glitch of 3 cycles on RX -> no FRAME_ERR, no valid, FSM back to IDLE.
//  6. Assert RESET at data bit 4 of 8'hFF -> all outputs 0 immediately.
//     Next full frame 8'h12 is delivered correctly.

Source files
------------

// File: rtl/uart_rx_console_if.sv
// Console-side bundle of the UART receive bridge: byte handshake plus status.
`timescale 1ns/1ps
interface uart_rx_console_if #(
    parameter int unsigned CNT_W = 3
);
    logic [7:0]       console_in;
    logic             console_in_valid;
    logic             console_in_ack;
    logic [CNT_W-1:0] fifo_count;
    logic             rx_overrun;
    logic             frame_err;

    modport master (
        output console_in, console_in_valid, fifo_count, rx_overrun, frame_err,
        input  console_in_ack
    );

    modport slave (
        input  console_in, console_in_valid, fifo_count, rx_overrun, frame_err,
        output console_in_ack
    );
endinterface

// File: rtl/uart_rx_console.sv
// 8N1 UART receiver feeding a small byte FIFO, drained over a four-phase
// valid/ack handshake toward the console consumer.
`timescale 1ns/1ps
module uart_rx_console #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    uart_rx_console_if.master  con
);
    localparam int unsigned DIV    = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W  = $clog2(DIV);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {O_IDLE, O_VALID, O_WAIT} out_state_t;

    rx_state_t        rstate;
    out_state_t       ostate;
    logic             rx_m, rx_s, rx_q;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [FCNT_W-1:0] count;
    logic              overrun;

    logic push_c, pop_c, full_c, write_c;

    // Metastability guard plus one extra stage for start-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_q <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_q <= rx_s;
        end
    end

    // Receive FSM: mid-bit sampling timed from the start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate        <= R_IDLE;
            baud_cnt      <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            con.frame_err <= 1'b0;
        end else begin
            con.frame_err <= 1'b0;
            case (rstate)
                R_IDLE: begin
                    if (rx_q && !rx_s) begin
                        baud_cnt <= '0;
                        rstate   <= R_START;
                    end
                end
                R_START: begin
                    if (baud_cnt == CNT_W'(DIV / 2 - 1)) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        rstate   <= rx_s ? R_IDLE : R_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                R_DATA: begin
                    if (baud_cnt == CNT_W'(DIV - 1)) begin
                        baud_cnt       <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) rstate  <= R_STOP;
                        else                 bit_idx <= bit_idx + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                R_STOP: begin
                    if (baud_cnt == CNT_W'(DIV - 1)) begin
                        baud_cnt <= '0;
                        if (!rx_s) con.frame_err <= 1'b1;
                        rstate <= R_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign push_c  = (rstate == R_STOP) && (baud_cnt == CNT_W'(DIV - 1)) && rx_s;
    assign pop_c   = (ostate == O_IDLE) && (count != '0);
    assign full_c  = (count == FCNT_W'(FIFO_DEPTH));
    assign write_c = push_c && (!full_c || pop_c);

    // Storage array carries no reset; occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (write_c) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (write_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)   rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_c && full_c && !pop_c) overrun <= 1'b1;
            case ({write_c, pop_c})
                2'b10:   count <= count + FCNT_W'(1);
                2'b01:   count <= count - FCNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign con.fifo_count = count;
    assign con.rx_overrun = overrun;

    // Four-phase handshake: valid drops only after ack has been released
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ostate               <= O_IDLE;
            con.console_in       <= 8'h00;
            con.console_in_valid <= 1'b0;
        end else begin
            case (ostate)
                O_IDLE: begin
                    if (pop_c) begin
                        con.console_in       <= mem[rd_ptr];
                        con.console_in_valid <= 1'b1;
                        ostate               <= O_VALID;
                    end
                end
                O_VALID: begin
                    if (con.console_in_ack) ostate <= O_WAIT;
                end
                O_WAIT: begin
                    if (!con.console_in_ack) begin
                        con.console_in_valid <= 1'b0;
                        ostate               <= O_IDLE;
                    end
                end
                default: ostate <= O_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_console.sv
// Directed bench for uart_rx_console at DIV=10 (1 MHz clock, 100 kbaud).
`timescale 1ns/1ps
module tb_uart_rx_console;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    int total = 0;
    int bad   = 0;

    uart_rx_console_if #(.CNT_W(3)) ifc ();

    uart_rx_console #(
        .CLK_FREQ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .con(ifc)
    );

    always #5 clk = ~clk;

    // Called on a negedge; each bit is held for 10 clocks
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (10) @(negedge clk);
        end
        rx = stop;
        repeat (10) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic handshake(input logic [7:0] exp, input string nm);
        int n = 0;
        while (ifc.console_in_valid !== 1'b1 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (ifc.console_in_valid !== 1'b1) begin
            bad++; $display("FAIL %s_valid: got %b want 1", nm, ifc.console_in_valid);
        end
        total++;
        if (ifc.console_in !== exp) begin
            bad++; $display("FAIL %s_data: got %h want %h", nm, ifc.console_in, exp);
        end
        @(negedge clk); ifc.console_in_ack = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (ifc.console_in_valid !== 1'b1) begin
            bad++; $display("FAIL %s_hold: got %b want 1", nm, ifc.console_in_valid);
        end
        ifc.console_in_ack = 1'b0;
        @(posedge clk); #1;
        total++;
        if (ifc.console_in_valid !== 1'b0) begin
            bad++; $display("FAIL %s_drop: got %b want 0", nm, ifc.console_in_valid);
        end
    endtask

    task automatic test_reset();
        ifc.console_in_ack = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({ifc.console_in, ifc.console_in_valid, ifc.fifo_count, ifc.rx_overrun, ifc.frame_err} !== 14'h0) begin
            bad++; $display("FAIL reset_outputs: got %h/%b/%0d/%b/%b want all 0",
                ifc.console_in, ifc.console_in_valid, ifc.fifo_count, ifc.rx_overrun, ifc.frame_err);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single();
        @(negedge clk);
        fork
            send_byte(8'h41, 1'b1);
            begin
                repeat (98) @(posedge clk); #1;
                total++;
                if (ifc.console_in_valid !== 1'b0 || ifc.fifo_count !== 3'd1) begin
                    bad++; $display("FAIL t1_push_cycle: valid=%b count=%0d want 0/1",
                        ifc.console_in_valid, ifc.fifo_count);
                end
                @(posedge clk); #1;
                total++;
                if (ifc.console_in_valid !== 1'b1 || ifc.console_in !== 8'h41 || ifc.fifo_count !== 3'd0) begin
                    bad++; $display("FAIL t1_latency: valid=%b data=%h count=%0d want 1/41/0",
                        ifc.console_in_valid, ifc.console_in, ifc.fifo_count);
                end
            end
        join
        handshake(8'h41, "t1_hs");
        total++;
        if (ifc.fifo_count !== 3'd0) begin
            bad++; $display("FAIL t1_count: got %0d want 0", ifc.fifo_count);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        send_byte(8'h50, 1'b1);
        send_byte(8'h41, 1'b1);
        send_byte(8'h0D, 1'b1);
        repeat (3) @(negedge clk);
        total++;
        if (ifc.fifo_count !== 3'd2 || ifc.console_in !== 8'h50) begin
            bad++; $display("FAIL t2_queue: count=%0d data=%h want 2/50", ifc.fifo_count, ifc.console_in);
        end
        handshake(8'h50, "t2_b0");
        handshake(8'h41, "t2_b1");
        handshake(8'h0D, "t2_b2");
    endtask

    task automatic test_overrun();
        @(negedge clk);
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b1);
        repeat (3) @(negedge clk);
        total++;
        if (ifc.fifo_count !== 3'd4 || ifc.console_in !== 8'h01 || ifc.rx_overrun !== 1'b1) begin
            bad++; $display("FAIL t3_full: count=%0d data=%h ovr=%b want 4/01/1",
                ifc.fifo_count, ifc.console_in, ifc.rx_overrun);
        end
        for (int i = 1; i <= 5; i++) handshake(8'(i), "t3_drain");
        repeat (5) @(negedge clk);
        total++;
        if (ifc.console_in_valid !== 1'b0 || ifc.fifo_count !== 3'd0 || ifc.rx_overrun !== 1'b1) begin
            bad++; $display("FAIL t3_sticky: valid=%b count=%0d ovr=%b want 0/0/1",
                ifc.console_in_valid, ifc.fifo_count, ifc.rx_overrun);
        end
    endtask

    task automatic test_frame_err();
        int n_fe = 0;
        int n_v  = 0;
        @(negedge clk);
        fork
            send_byte(8'hA5, 1'b0);
            for (int i = 0; i < 115; i++) begin
                @(negedge clk);
                if (ifc.frame_err === 1'b1) n_fe++;
                if (ifc.console_in_valid !== 1'b0) n_v++;
            end
        join
        total++;
        if (n_fe != 1) begin
            bad++; $display("FAIL t4_pulse: got %0d pulses want 1", n_fe);
        end
        total++;
        if (n_v != 0 || ifc.fifo_count !== 3'd0) begin
            bad++; $display("FAIL t4_discard: valid cycles=%0d count=%0d want 0/0", n_v, ifc.fifo_count);
        end
        send_byte(8'h33, 1'b1);
        handshake(8'h33, "t4_next");
    endtask

    task automatic test_glitch();
        int n_bad = 0;
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ifc.frame_err !== 1'b0 || ifc.console_in_valid !== 1'b0 || ifc.fifo_count !== 3'd0) n_bad++;
        end
        total++;
        if (n_bad != 0) begin
            bad++; $display("FAIL t5_glitch: got %0d active cycles want 0", n_bad);
        end
        send_byte(8'h5A, 1'b1);
        handshake(8'h5A, "t5_next");
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (45) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({ifc.console_in, ifc.console_in_valid, ifc.fifo_count, ifc.rx_overrun, ifc.frame_err} !== 14'h0) begin
            bad++; $display("FAIL t6_async: got %h/%b/%0d/%b/%b want all 0",
                ifc.console_in, ifc.console_in_valid, ifc.fifo_count, ifc.rx_overrun, ifc.frame_err);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        total++;
        if (ifc.console_in_valid !== 1'b0 || ifc.frame_err !== 1'b0) begin
            bad++; $display("FAIL t6_quiet: valid=%b fe=%b want 0/0", ifc.console_in_valid, ifc.frame_err);
        end
        send_byte(8'h12, 1'b1);
        handshake(8'h12, "t6_next");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
